// File: rtl/kanagawa_credit_sender.sv
// Credit-flow-controlled link sender: a 2-entry input FIFO drains downstream only while credits remain.
// Optional sticky credit-overflow checker enabled by defining KANAGAWA_CREDIT_SENDER_CHECK_EN.
module kanagawa_credit_sender #(
    parameter int WIDTH   = 32,
    parameter int CREDITS = 4,
    localparam int CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_data_in,
    input  logic             input_valid_in,
    output logic             input_ready_out,
    output logic [WIDTH-1:0] output_data_out,
    output logic             output_valid_out,
    input  logic             credit_return_in,
    output logic [CNT_W-1:0] credits_available_out,
    output logic             credit_error_out
);

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CRED_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             ready_q;
    logic             ready_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_s;
    logic             send_s;

    assign accept_s = input_valid_in && ready_q;
    assign send_s   = (occ_q != 2'd0) && (cnt_q != {CNT_W{1'b0}});

    // Occupancy and ready are derived from the post-edge fill level
    always_comb begin
        occ_d = occ_q;
        case ({accept_s, send_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        ready_d = (occ_d < 2'd2);
    end

    // Credit count: a return with the count already full saturates instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        case ({send_s, credit_return_in})
            2'b10: cnt_d = cnt_q - CRED_ONE;
            2'b01: begin
                if (cnt_q == CRED_MAX) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CRED_ONE;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= 2'd0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            cnt_q    <= CRED_MAX;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            ready_q <= ready_d;
            valid_q <= send_s;
            cnt_q   <= cnt_d;
            if (accept_s) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (send_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Payload storage and output data hold their contents across reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= input_data_in;
        end
        if (send_s) begin
            data_q <= mem_q[rd_ptr_q];
        end
    end

`ifdef KANAGAWA_CREDIT_SENDER_CHECK_EN
    logic overflow_s;
    logic err_q;

    assign overflow_s = credit_return_in && !send_s && (cnt_q == CRED_MAX);

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (overflow_s) begin
            err_q <= 1'b1;
            $error("%m credit overflow");
        end else begin
            err_q <= err_q;
        end
    end

    assign credit_error_out = err_q;
`else
    assign credit_error_out = 1'b0;
`endif

    assign input_ready_out       = ready_q;
    assign output_valid_out      = valid_q;
    assign output_data_out       = data_q;
    assign credits_available_out = cnt_q;

endmodule

// File: tb/tb_kanagawa_credit_sender.sv
// Bench for kanagawa_credit_sender: directed scenarios plus random traffic against a queue-based model.
module tb_kanagawa_credit_sender;

    localparam int WIDTH   = 32;
    localparam int CREDITS = 4;
    localparam int CNT_W   = $clog2(CREDITS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             vin;
    logic             ret;
    logic             ready_o;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic [CNT_W-1:0] cred_o;
    logic             err_o;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    logic [WIDTH-1:0] mq [$];
    int               m_cred;
    bit               m_ready;
    bit               m_valid;
    bit               m_err;
    logic [WIDTH-1:0] m_data;

    kanagawa_credit_sender #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst),
        .input_data_in(din), .input_valid_in(vin), .input_ready_out(ready_o),
        .output_data_out(dout), .output_valid_out(vout),
        .credit_return_in(ret), .credits_available_out(cred_o),
        .credit_error_out(err_o)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the transaction-level model, sample 1 time unit after the edge
    task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit cr);
        bit snd;
        bit acc;
        rst = r; vin = v; din = d; ret = cr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_cred = CREDITS; m_ready = 1'b1; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            snd = (mq.size() != 0) && (m_cred != 0);
            acc = v && m_ready;
`ifdef KANAGAWA_CREDIT_SENDER_CHECK_EN
            if (cr && !snd && m_cred == CREDITS) m_err = 1'b1;
`endif
            m_valid = snd;
            if (snd) m_data = mq.pop_front();
            if (acc) mq.push_back(d);
            m_cred = m_cred - (snd ? 1 : 0) + (cr ? 1 : 0);
            if (m_cred > CREDITS) m_cred = CREDITS;
            m_ready = (mq.size() < 2);
        end
        #1;
        if (vout === 1'b1) pulses++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h1234, 1'b1);
        tests++;
        if (ready_o !== 1'b1 || vout !== 1'b0 || cred_o !== 3'd4 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset ready=%b valid=%b cred=%0d err=%b required 1 0 4 0", ready_o, vout, cred_o, err_o);
        end
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, 32'hA5, 1'b0);
        tests++;
        if (vout !== 1'b0 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL single_e1 valid=%b ready=%b required 0 1", vout, ready_o);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (vout !== 1'b1 || dout !== 32'hA5 || cred_o !== 3'd3) begin
            fails++;
            $display("FAIL single_e2 valid=%b data=%h cred=%0d required 1 a5 3", vout, dout, cred_o);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (vout !== 1'b0 || cred_o !== 3'd3) begin
            fails++;
            $display("FAIL single_e3 valid=%b cred=%0d required 0 3", vout, cred_o);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (cred_o !== 3'd4) begin
            fails++;
            $display("FAIL single_return cred=%0d required 4", cred_o);
        end
    endtask

    task automatic test_exhaustion();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h100 + i, 1'b0);
            tests++;
            if (vout !== m_valid || (m_valid && dout !== m_data) || ready_o !== m_ready || cred_o !== CNT_W'(m_cred)) begin
                fails++;
                $display("FAIL exhaust cyc=%0d valid=%b/%b data=%h/%h ready=%b/%b cred=%0d/%0d",
                         i, vout, m_valid, dout, m_data, ready_o, m_ready, cred_o, m_cred);
            end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pulses !== 4 || ready_o !== 1'b0 || cred_o !== 3'd0 || mq.size() != 2) begin
            fails++;
            $display("FAIL exhaust_end pulses=%0d ready=%b cred=%0d held=%0d required 4 0 0 2", pulses, ready_o, cred_o, mq.size());
        end
    endtask

    task automatic test_recovery();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (cred_o !== 3'd1 || vout !== 1'b0 || ready_o !== 1'b0) begin
            fails++;
            $display("FAIL recover_ret cred=%0d valid=%b ready=%b required 1 0 0", cred_o, vout, ready_o);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (vout !== 1'b1 || dout !== 32'h104 || cred_o !== 3'd0 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL recover_send valid=%b data=%h cred=%0d ready=%b required 1 104 0 1", vout, dout, cred_o, ready_o);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, (m_cred < CREDITS) ? 1'b1 : 1'b0);
            tests++;
            if (vout !== m_valid || (m_valid && dout !== m_data) || cred_o !== CNT_W'(m_cred)) begin
                fails++;
                $display("FAIL drain cyc=%0d valid=%b/%b data=%h/%h cred=%0d/%0d", i, vout, m_valid, dout, m_data, cred_o, m_cred);
            end
        end
    endtask

    task automatic test_streaming();
        bit pred_send;
        pulses = 0;
        for (int i = 0; i < 101; i++) begin
            pred_send = (mq.size() != 0) && (m_cred != 0);
            step(1'b0, 1'b1, $urandom, pred_send);
            tests++;
            if (vout !== m_valid || (m_valid && dout !== m_data) || ready_o !== m_ready || cred_o !== CNT_W'(m_cred)) begin
                fails++;
                $display("FAIL stream cyc=%0d valid=%b/%b data=%h/%h ready=%b/%b cred=%0d/%0d",
                         i, vout, m_valid, dout, m_data, ready_o, m_ready, cred_o, m_cred);
            end
        end
        tests++;
        if (pulses !== 100 || cred_o !== 3'd4) begin
            fails++;
            $display("FAIL stream_rate pulses=%0d cred=%0d required 100 4", pulses, cred_o);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, (m_cred < CREDITS) ? 1'b1 : 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0);
            tests++;
            if (vout !== m_valid || (m_valid && dout !== m_data) || ready_o !== m_ready ||
                cred_o !== CNT_W'(m_cred) || err_o !== m_err) begin
                fails++;
                $display("FAIL random cyc=%0d valid=%b/%b data=%h/%h ready=%b/%b cred=%0d/%0d err=%b/%b",
                         i, vout, m_valid, dout, m_data, ready_o, m_ready, cred_o, m_cred, err_o, m_err);
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if (cred_o !== 3'd4 || err_o !== m_err) begin
            fails++;
            $display("FAIL overflow cred=%0d err=%b required 4 %b", cred_o, err_o, m_err);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (err_o !== m_err) begin
            fails++;
            $display("FAIL overflow_hold err=%b required %b", err_o, m_err);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h200 + i, 1'b0);
        tests++;
        if (cred_o !== 3'd0 || ready_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_fill cred=%0d ready=%b required 0 0", cred_o, ready_o);
        end
        step(1'b1, 1'b1, 32'h300, 1'b1);
        tests++;
        if (vout !== 1'b0 || ready_o !== 1'b1 || cred_o !== 3'd4 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset valid=%b ready=%b cred=%0d err=%b required 0 1 4 0", vout, ready_o, cred_o, err_o);
        end
        pulses = 0;
        step(1'b0, 1'b1, 32'h5A, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (vout !== 1'b1 || dout !== 32'h5A || cred_o !== 3'd3) begin
            fails++;
            $display("FAIL post_reset_item valid=%b data=%h cred=%0d required 1 5a 3", vout, dout, cred_o);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL post_reset_pulses got=%0d required 1", pulses);
        end
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; din = '0; ret = 1'b0;
        m_cred = CREDITS; m_ready = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_data = '0;
        test_reset();
        test_single();
        test_exhaustion();
        test_recovery();
        test_streaming();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
